// File: rtl/hk_pkg.sv
// Shared types and constants for the Knight player controller: state encoding,
// status codes presented to sprite/hit logic, and the keyboard keycodes it decodes.
package hk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK    = 3'd1,
        JUMP    = 3'd2,
        FALL    = 3'd3,
        ATTACK  = 3'd4,
        HURT    = 3'd5,
        RESPAWN = 3'd6,
        DEAD    = 3'd7
    } state_e;

    localparam logic [3:0] STATUS_IDLE    = 4'd0;
    localparam logic [3:0] STATUS_WALK    = 4'd1;
    localparam logic [3:0] STATUS_JUMP    = 4'd2;
    localparam logic [3:0] STATUS_FALL    = 4'd3;
    localparam logic [3:0] STATUS_ATTACK  = 4'd4;
    localparam logic [3:0] STATUS_HURT    = 4'd5;
    localparam logic [3:0] STATUS_RESPAWN = 4'd6;
    localparam logic [3:0] STATUS_DEAD    = 4'd7;

    localparam logic [7:0] KEY_LEFT   = 8'h50;
    localparam logic [7:0] KEY_RIGHT  = 8'h4F;
    localparam logic [7:0] KEY_JUMP   = 8'h52;
    localparam logic [7:0] KEY_DOWN   = 8'h51;
    localparam logic [7:0] KEY_ATTACK = 8'h1B;

    localparam int HURT_FRAMES = 8;

    function automatic logic [3:0] status_of(input state_e s);
        logic [3:0] code;
        case (s)
            IDLE:    code = STATUS_IDLE;
            WALK:    code = STATUS_WALK;
            JUMP:    code = STATUS_JUMP;
            FALL:    code = STATUS_FALL;
            ATTACK:  code = STATUS_ATTACK;
            HURT:    code = STATUS_HURT;
            RESPAWN: code = STATUS_RESPAWN;
            DEAD:    code = STATUS_DEAD;
            default: code = STATUS_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating down-counter used for every per-frame timer in the player controller.
// A load takes precedence over the decrement; expire marks the frame the count reaches zero.
module frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             expire,
    output logic             busy_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value     = count_q;
    assign expire    = !load && (count_q == WIDTH'(1));
    assign busy_next = (count_d != '0);

endmodule

// File: rtl/player_action_ctrl.sv
// Per-frame Knight player controller: keycode decode, motion commands, attack windows,
// lives, invulnerability, respawn and game-over. Optional DOUBLE_JUMP_EN allows one air jump.
module player_action_ctrl
    import hk_pkg::*;
#(
    parameter int WALK_STEP       = 2,
    parameter int JUMP_STEP       = 6,
    parameter int FALL_STEP       = 6,
    parameter int ATTACK_FRAMES   = 12,
    parameter int ATTACK_COOLDOWN = 8,
    parameter int INVULN_FRAMES   = 60,
    parameter int RESPAWN_FRAMES  = 30,
    parameter int START_LIFE      = 5
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       on_ground,
    input  logic       at_apex,
    input  logic       hit,
    input  logic       fell,
    output logic [9:0] x_step,
    output logic [9:0] y_step,
    output logic [3:0] status,
    output logic       inverse,
    output logic [3:0] life,
    output logic       attack_active,
    output logic       invuln,
    output logic       respawn,
    output logic       game_over
);

    localparam int ATK_W = $clog2(ATTACK_FRAMES + 1);
    localparam int CD_W  = $clog2(ATTACK_COOLDOWN + 1);
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int HRT_W = $clog2(HURT_FRAMES + 1);
    localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [9:0] WALK_POS = 10'(WALK_STEP);
    localparam logic [9:0] WALK_NEG = 10'(-WALK_STEP);
    localparam logic [9:0] JUMP_NEG = 10'(-JUMP_STEP);
    localparam logic [9:0] FALL_POS = 10'(FALL_STEP);

    state_e     state_q, state_d;
    logic [9:0] x_step_q, x_step_d;
    logic [9:0] y_step_q, y_step_d;
    logic [3:0] status_q, status_d;
    logic       inverse_q, inverse_d;
    logic [3:0] life_q, life_d;
    logic       attack_active_q, attack_active_d;
    logic       invuln_q, invuln_d;
    logic       respawn_q, respawn_d;
    logic       game_over_q, game_over_d;
    logic [7:0] prev_key_q;

    logic key_left, key_right, key_jump, key_down, key_attack;
    logic attack_go;
    logic [9:0] steer_x, air_x, gravity_y;
    logic       steer_inv;
    logic [3:0] life_dec;

    logic atk_load, cd_load, inv_load, hurt_load, rsp_load;
    logic [ATK_W-1:0] atk_value;
    logic [CD_W-1:0]  cd_value;
    logic [INV_W-1:0] inv_value;
    logic [HRT_W-1:0] hurt_value;
    logic [RSP_W-1:0] rsp_value;
    logic atk_expire, cd_expire, inv_expire, hurt_expire, rsp_expire;
    logic atk_busy, cd_busy, inv_busy, hurt_busy, rsp_busy;

`ifdef DOUBLE_JUMP_EN
    logic dj_avail_q, dj_avail_d;
    logic dj_go;
`endif

    frame_timer #(.WIDTH(ATK_W)) u_attack_timer (
        .clk(frame_clk), .rst(Reset), .load(atk_load), .load_val(ATK_W'(ATTACK_FRAMES)),
        .value(atk_value), .expire(atk_expire), .busy_next(atk_busy)
    );

    frame_timer #(.WIDTH(CD_W)) u_cooldown_timer (
        .clk(frame_clk), .rst(Reset), .load(cd_load), .load_val(CD_W'(ATTACK_COOLDOWN)),
        .value(cd_value), .expire(cd_expire), .busy_next(cd_busy)
    );

    frame_timer #(.WIDTH(INV_W)) u_invuln_timer (
        .clk(frame_clk), .rst(Reset), .load(inv_load), .load_val(INV_W'(INVULN_FRAMES)),
        .value(inv_value), .expire(inv_expire), .busy_next(inv_busy)
    );

    frame_timer #(.WIDTH(HRT_W)) u_hurt_timer (
        .clk(frame_clk), .rst(Reset), .load(hurt_load), .load_val(HRT_W'(HURT_FRAMES)),
        .value(hurt_value), .expire(hurt_expire), .busy_next(hurt_busy)
    );

    frame_timer #(.WIDTH(RSP_W)) u_respawn_timer (
        .clk(frame_clk), .rst(Reset), .load(rsp_load), .load_val(RSP_W'(RESPAWN_FRAMES)),
        .value(rsp_value), .expire(rsp_expire), .busy_next(rsp_busy)
    );

    logic unused_timer_bits;
    assign unused_timer_bits = ^{atk_value, atk_busy, cd_expire, cd_busy, inv_value, inv_expire,
                                 hurt_value, hurt_busy, rsp_value, rsp_busy};

    // Attack only triggers on the keycode edge, so holding the key never retriggers.
    always_comb begin
        key_left   = (keycode == KEY_LEFT);
        key_right  = (keycode == KEY_RIGHT);
        key_jump   = (keycode == KEY_JUMP);
        key_down   = (keycode == KEY_DOWN);
        key_attack = (keycode == KEY_ATTACK);
        attack_go  = key_attack && (prev_key_q != KEY_ATTACK) && (cd_value == '0);
`ifdef DOUBLE_JUMP_EN
        dj_go      = key_jump && (prev_key_q != KEY_JUMP) && dj_avail_q;
`endif
        steer_x    = key_left ? WALK_NEG : (key_right ? WALK_POS : 10'd0);
        steer_inv  = key_left ? 1'b1 : (key_right ? 1'b0 : inverse_q);
        air_x      = on_ground ? 10'd0 : steer_x;
        gravity_y  = on_ground ? 10'd0 : FALL_POS;
        life_dec   = (life_q != 4'd0) ? (life_q - 4'd1) : 4'd0;
    end

    always_comb begin
        state_d   = state_q;
        x_step_d  = x_step_q;
        y_step_d  = y_step_q;
        inverse_d = inverse_q;
        life_d    = life_q;
        respawn_d = 1'b0;
        atk_load  = 1'b0;
        cd_load   = 1'b0;
        inv_load  = 1'b0;
        hurt_load = 1'b0;
        rsp_load  = 1'b0;
`ifdef DOUBLE_JUMP_EN
        dj_avail_d = dj_avail_q;
        if (on_ground && (state_q != JUMP)) begin
            dj_avail_d = 1'b1;
        end
`endif

        if (fell && (state_q != RESPAWN) && (state_q != DEAD)) begin
            life_d   = life_dec;
            x_step_d = 10'd0;
            y_step_d = 10'd0;
            if (life_dec == 4'd0) begin
                state_d = DEAD;
            end else begin
                state_d   = RESPAWN;
                respawn_d = 1'b1;
                rsp_load  = 1'b1;
            end
        end else if (hit && !invuln_q && (state_q != RESPAWN) && (state_q != DEAD)) begin
            life_d   = life_dec;
            x_step_d = 10'd0;
            inv_load = 1'b1;
            if (life_dec == 4'd0) begin
                state_d  = DEAD;
                y_step_d = 10'd0;
            end else begin
                state_d   = HURT;
                hurt_load = 1'b1;
                y_step_d  = gravity_y;
            end
        end else begin
            case (state_q)
                IDLE, WALK: begin
                    if (attack_go) begin
                        state_d   = ATTACK;
                        atk_load  = 1'b1;
                        x_step_d  = air_x;
                        y_step_d  = gravity_y;
                    end else if (key_jump) begin
                        state_d  = JUMP;
                        x_step_d = 10'd0;
                        y_step_d = JUMP_NEG;
                    end else if (!on_ground) begin
                        state_d   = FALL;
                        x_step_d  = steer_x;
                        inverse_d = steer_inv;
                        y_step_d  = FALL_POS;
                    end else if (key_left || key_right) begin
                        state_d   = WALK;
                        x_step_d  = steer_x;
                        inverse_d = steer_inv;
                        y_step_d  = 10'd0;
                    end else if (!key_down) begin
                        state_d  = IDLE;
                        x_step_d = 10'd0;
                        y_step_d = 10'd0;
                    end
                end

                JUMP: begin
                    x_step_d  = steer_x;
                    inverse_d = steer_inv;
                    if (attack_go) begin
                        state_d  = ATTACK;
                        atk_load = 1'b1;
                        x_step_d = air_x;
`ifdef DOUBLE_JUMP_EN
                    end else if (dj_go) begin
                        y_step_d   = JUMP_NEG;
                        dj_avail_d = 1'b0;
`endif
                    end else if (at_apex || key_down) begin
                        state_d  = FALL;
                        y_step_d = FALL_POS;
                    end else begin
                        y_step_d = JUMP_NEG;
                    end
                end

                FALL: begin
                    x_step_d  = steer_x;
                    inverse_d = steer_inv;
                    if (attack_go) begin
                        state_d  = ATTACK;
                        atk_load = 1'b1;
                        x_step_d = air_x;
                        y_step_d = gravity_y;
`ifdef DOUBLE_JUMP_EN
                    end else if (dj_go) begin
                        state_d    = JUMP;
                        y_step_d   = JUMP_NEG;
                        dj_avail_d = 1'b0;
`endif
                    end else if (on_ground) begin
                        state_d  = IDLE;
                        x_step_d = 10'd0;
                        y_step_d = 10'd0;
                    end else begin
                        y_step_d = FALL_POS;
                    end
                end

                // A rising attack keeps its upward step until the apex, then falls.
                ATTACK: begin
                    if (atk_expire) begin
                        cd_load = 1'b1;
                        if (!on_ground) begin
                            state_d   = FALL;
                            x_step_d  = steer_x;
                            inverse_d = steer_inv;
                            y_step_d  = FALL_POS;
                        end else begin
                            state_d  = IDLE;
                            x_step_d = 10'd0;
                            y_step_d = 10'd0;
                        end
                    end else begin
                        x_step_d  = air_x;
                        inverse_d = steer_inv;
                        if (on_ground) begin
                            y_step_d = 10'd0;
                        end else if (at_apex || (y_step_q != JUMP_NEG)) begin
                            y_step_d = FALL_POS;
                        end
                    end
                end

                HURT: begin
                    x_step_d = 10'd0;
                    y_step_d = gravity_y;
                    if (hurt_expire) begin
                        state_d = on_ground ? IDLE : FALL;
                    end
                end

                RESPAWN: begin
                    x_step_d = 10'd0;
                    y_step_d = 10'd0;
                    if (rsp_expire) begin
                        state_d  = IDLE;
                        inv_load = 1'b1;
                    end
                end

                DEAD: begin
                    x_step_d = 10'd0;
                    y_step_d = 10'd0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        status_d        = status_of(state_d);
        attack_active_d = (state_d == ATTACK);
        game_over_d     = (state_d == DEAD);
        invuln_d        = inv_busy;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= IDLE;
            x_step_q        <= 10'd0;
            y_step_q        <= 10'd0;
            status_q        <= STATUS_IDLE;
            inverse_q       <= 1'b0;
            life_q          <= 4'(START_LIFE);
            attack_active_q <= 1'b0;
            invuln_q        <= 1'b0;
            respawn_q       <= 1'b0;
            game_over_q     <= 1'b0;
            prev_key_q      <= 8'h00;
        end else begin
            state_q         <= state_d;
            x_step_q        <= x_step_d;
            y_step_q        <= y_step_d;
            status_q        <= status_d;
            inverse_q       <= inverse_d;
            life_q          <= life_d;
            attack_active_q <= attack_active_d;
            invuln_q        <= invuln_d;
            respawn_q       <= respawn_d;
            game_over_q     <= game_over_d;
            prev_key_q      <= keycode;
        end
    end

`ifdef DOUBLE_JUMP_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dj_avail_q <= 1'b1;
        end else begin
            dj_avail_q <= dj_avail_d;
        end
    end
`endif

    assign x_step        = x_step_q;
    assign y_step        = y_step_q;
    assign status        = status_q;
    assign inverse       = inverse_q;
    assign life          = life_q;
    assign attack_active = attack_active_q;
    assign invuln        = invuln_q;
    assign respawn       = respawn_q;
    assign game_over     = game_over_q;

endmodule
